// File: rtl/encoder4to2_reg_pkg.sv
// Shared widths, constants and types for the 4-to-2 encoder and its matching 2-to-4 decoder.
package encoder4to2_reg_pkg;

   localparam int IDX_W  = 2;
   localparam int WORD_W = 4;
   localparam logic [WORD_W-1:0] ONEHOT_ZERO = '0;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } state_e;

   typedef struct packed {
      logic [IDX_W-1:0] idx;
      logic             zero;
      logic             multi;
   } enc_res_t;

endpackage

// File: rtl/decorder2to4.sv
// 2-to-4 one-hot decoder; the inverse of encoder4to2_reg on the same bus.
module decorder2to4
   import encoder4to2_reg_pkg::*;
(
   input  logic [IDX_W-1:0]  a,
   output logic [WORD_W-1:0] y
);

   always_comb begin
      y    = ONEHOT_ZERO;
      y[a] = 1'b1;
   end

endmodule

// File: rtl/encoder4to2_reg_prio_enc4.sv
// Combinational 4-bit priority encoder; direction of priority chosen by PRIO_HIGH.
module prio_enc4
   import encoder4to2_reg_pkg::*;
#(
   parameter bit PRIO_HIGH = 1'b1
) (
   input  logic [WORD_W-1:0] d,
   output enc_res_t          res
);

   always_comb begin
      res = '0;
      // Scan away from the winning end so the last hit is the priority bit.
      if (PRIO_HIGH) begin
         for (int i = 0; i < WORD_W; i++) begin
            if (d[i]) res.idx = IDX_W'(i);
         end
      end else begin
         for (int i = WORD_W - 1; i >= 0; i--) begin
            if (d[i]) res.idx = IDX_W'(i);
         end
      end
      res.zero  = (d == ONEHOT_ZERO);
      res.multi = |(d & (d - WORD_W'(1)));
   end

endmodule

// File: rtl/encoder4to2_reg.sv
// Registered 4-to-2 priority encoder with valid/ready handshake, status flags
// and a saturating count of malformed (zero or multi-hot) words.
module encoder4to2_reg
   import encoder4to2_reg_pkg::*;
#(
   parameter bit PRIO_HIGH = 1'b1,
   parameter int CNT_W     = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [WORD_W-1:0] d,
   input  logic              d_valid,
   output logic              d_ready,
   output logic [IDX_W-1:0]  y,
   output logic              y_zero,
   output logic              y_multi,
   output logic              y_valid,
   input  logic              y_ready,
   output logic [CNT_W-1:0]  err_cnt,
   input  logic              clr_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_e           state_q, state_d;
   enc_res_t         res_q, res_d;
   enc_res_t         enc;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             accept;

   prio_enc4 #(.PRIO_HIGH(PRIO_HIGH)) u_enc (
      .d   (d),
      .res (enc)
   );

   // A held result can be replaced in the same cycle it is consumed.
   assign d_ready = (state_q == ST_EMPTY) | y_ready;
   assign accept  = d_valid & d_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_EMPTY;
         res_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         res_q   <= res_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_EMPTY: if (accept) state_d = ST_FULL;
         ST_FULL:  if (y_ready && !d_valid) state_d = ST_EMPTY;
         default:  state_d = ST_EMPTY;
      endcase
   end

   always_comb begin
      res_d = res_q;
      if (accept) res_d = enc;
   end

   // Clear beats increment; count sticks at all-ones.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_cnt) begin
         cnt_d = '0;
      end else if (accept && (enc.zero || enc.multi) && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_comb begin
      y_valid = (state_q == ST_FULL);
      y       = res_q.idx;
      y_zero  = res_q.zero;
      y_multi = res_q.multi;
      err_cnt = cnt_q;
   end

endmodule
